// File: rtl/uart_pkg.sv
// uart_pkg: constants shared with the UART transmitter and the receiver state encoding
package uart_pkg;
    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_W = 8;
    localparam logic IDLE_LVL = 1'b1;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} rx_state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: multi-flop synchronizer for the RX pin plus falling-edge detector
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic sysclk,
    input  logic reset,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    // shift the pin through the synchronizer and remember the previous synced level
    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{IDLE_LVL}};
            prev_q <= IDLE_LVL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end
    assign rx_s_o = sync_q[SYNC_STAGES-1];
    assign fall_o = !rx_s_o && prev_q;
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver, oversampled by baud ticks, with framing-error flag
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              BRclk,
    input  logic              UART_RX,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              RX_STATUS,
    output logic              RX_ERR,
    output logic              RX_BUSY
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_W);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);
    rx_state_t         state_q;
    logic [TW-1:0]     tcnt_q;
    logic [BW-1:0]     bcnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] data_q;
    logic              status_q;
    logic              err_q;
    logic              rx_s;
    logic              fall;
    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .sysclk(sysclk),
        .reset (reset),
        .rx_i  (UART_RX),
        .rx_s_o(rx_s),
        .fall_o(fall)
    );
    // frame FSM: start qualification at half-bit, data/stop sampled at each bit centre
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            tcnt_q   <= '0;
            bcnt_q   <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            status_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            status_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                S_IDLE: if (fall) begin
                    tcnt_q  <= '0;
                    state_q <= S_START;
                end
                S_START: if (BRclk) begin
                    tcnt_q <= tcnt_q + 1'b1;
                    if (tcnt_q == T_MID) begin
                        tcnt_q  <= '0;
                        bcnt_q  <= '0;
                        state_q <= rx_s ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: if (BRclk) begin
                    tcnt_q <= tcnt_q + 1'b1;
                    if (tcnt_q == T_END) begin
                        shift_q[bcnt_q] <= rx_s;
                        bcnt_q          <= bcnt_q + 1'b1;
                        if (bcnt_q == B_LAST) state_q <= S_STOP;
                    end
                end
                S_STOP: if (BRclk) begin
                    tcnt_q <= tcnt_q + 1'b1;
                    if (tcnt_q == T_END) begin
                        if (rx_s) begin
                            data_q   <= shift_q;
                            status_q <= 1'b1;
                            state_q  <= S_IDLE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_BREAK;
                        end
                    end
                end
                S_BREAK: if (rx_s) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
    assign RX_DATA   = data_q;
    assign RX_STATUS = status_q;
    assign RX_ERR    = err_q;
    assign RX_BUSY   = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized frame stimulus against a frame-level scoreboard
module tb_uart_receiver;
    localparam int OS = 16;
    localparam int SYNC = 2;
    localparam int LAT = OS / 2 + 9 * OS;
    typedef struct {
        logic       err;
        logic [7:0] data;
        int         t0;
    } exp_t;
    logic       sysclk = 1'b0;
    logic       reset = 1'b1;
    logic       BRclk = 1'b0;
    logic       UART_RX = 1'b1;
    logic [7:0] RX_DATA;
    logic       RX_STATUS, RX_ERR, RX_BUSY;
    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         tick_cnt = 0;
    int         br_div = 4;
    int         br_cnt = 0;
    logic [7:0] model_last = 8'h00;

    uart_receiver #(.OVERSAMPLE(OS), .SYNC_STAGES(SYNC)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .BRclk    (BRclk),
        .UART_RX  (UART_RX),
        .RX_DATA  (RX_DATA),
        .RX_STATUS(RX_STATUS),
        .RX_ERR   (RX_ERR),
        .RX_BUSY  (RX_BUSY)
    );

    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        br_cnt = (br_cnt + 1 >= br_div) ? 0 : br_cnt + 1;
        BRclk = (br_cnt == 0);
    end

    always @(posedge sysclk) if (BRclk) tick_cnt <= tick_cnt + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    always @(negedge sysclk) begin
        if (!reset && (RX_STATUS || RX_ERR)) begin
            exp_t e;
            int   lat;
            chk("status_err_exclusive", int'(RX_STATUS && RX_ERR), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                lat = tick_cnt - e.t0;
                chk("pulse_kind_err", int'(RX_ERR), int'(e.err));
                chk("rx_data", int'(RX_DATA), int'(e.data));
                checks++;
                if (lat < LAT || lat > LAT + SYNC + 1) begin
                    failures++;
                    $display("FAIL latency: got %0d ticks, required %0d..%0d", lat, LAT, LAT + SYNC + 1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge sysclk);
        while (!BRclk) @(posedge sysclk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int low_after, input int gap);
        exp_t e;
        UART_RX = 1'b0;
        if (stop_ok) model_last = d;
        e.err = !stop_ok;
        e.data = model_last;
        e.t0 = tick_cnt;
        exp_q.push_back(e);
        ticks(OS);
        for (int i = 0; i < 8; i++) begin
            UART_RX = d[i];
            ticks(OS);
        end
        UART_RX = stop_ok;
        ticks(OS);
        if (!stop_ok) begin
            ticks(low_after);
            UART_RX = 1'b1;
            ticks(OS);
        end
        ticks(gap);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge sysclk);
            n++;
        end
        ticks(2 * OS);
        chk("drain_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        repeat (4) @(posedge sysclk);
        #1;
        reset = 1'b0;
        @(negedge sysclk);
        chk("reset_rx_data", int'(RX_DATA), 0);
        chk("reset_status", int'(RX_STATUS), 0);
        chk("reset_err", int'(RX_ERR), 0);
        chk("reset_busy", int'(RX_BUSY), 0);
        ticks(OS);

        send_frame(8'hA5, 1'b1, 0, OS);
        drain();
        chk("good_frame_data", int'(RX_DATA), 8'hA5);

        send_frame(8'h00, 1'b1, 0, 0);
        send_frame(8'hFF, 1'b1, 0, 0);
        send_frame(8'h3C, 1'b1, 0, OS);
        drain();

        UART_RX = 1'b0;
        ticks(3);
        UART_RX = 1'b1;
        ticks(2 * OS);
        chk("glitch_busy", int'(RX_BUSY), 0);
        chk("glitch_data", int'(RX_DATA), int'(model_last));

        send_frame(8'h5A, 1'b0, 40, 0);
        drain();
        chk("ferr_data_held", int'(RX_DATA), 8'h3C);
        send_frame(8'h81, 1'b1, 0, OS);
        drain();

        UART_RX = 1'b0;
        ticks(OS);
        for (int i = 0; i < 4; i++) begin
            UART_RX = (i < 2);
            ticks(OS);
        end
        chk("midframe_busy", int'(RX_BUSY), 1);
        reset = 1'b1;
        UART_RX = 1'b1;
        @(posedge sysclk);
        #1;
        reset = 1'b0;
        model_last = 8'h00;
        chk("midreset_data", int'(RX_DATA), 0);
        chk("midreset_status", int'(RX_STATUS), 0);
        chk("midreset_err", int'(RX_ERR), 0);
        chk("midreset_busy", int'(RX_BUSY), 0);
        ticks(2 * OS);
        send_frame(8'h42, 1'b1, 0, OS);
        drain();

        br_div = 1;
        ticks(OS);
        send_frame(8'h96, 1'b1, 0, OS);
        drain();
        chk("brclk_high_data", int'(RX_DATA), 8'h96);

        for (int k = 0; k < 24; k++) begin
            logic [7:0] d;
            logic       ok;
            d = 8'($urandom);
            ok = $urandom_range(0, 4) != 0;
            if (k % 6 == 0) begin
                drain();
                br_div = $urandom_range(1, 6);
                ticks(OS);
            end
            send_frame(d, ok, $urandom_range(OS, 40), $urandom_range(0, 2) * OS);
        end
        drain();
        chk("final_data", int'(RX_DATA), int'(model_last));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel receiver for the CPU's UART peripheral: 8N1 frames, LSB first, 16 baud-rate ticks per bit, matching the frame format our transmitter produces. It samples the asynchronous `UART_RX` line in the `sysclk` domain, qualified by a one-cycle baud tick. It delivers each byte to the peripheral bus logic with a one-cycle valid strobe and flags framing errors. Sits between the board RX pin and the memory-mapped UART register block.

## Interface
- `OVERSAMPLE`, 16: baud ticks per bit; power of two, ≥ 8; `MID` = `OVERSAMPLE/2`.
- `SYNC_STAGES`, 2: flops in the `UART_RX` synchronizer, ≥ 2.
- `sysclk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; wins over every other input in the same cycle.
- `BRclk`  in  1  baud tick enable, `sysclk`-synchronous, one cycle high per 1/`OVERSAMPLE` bit period; level-sampled; held high, every cycle counts as a tick.
- `UART_RX`  in  1  asynchronous serial line, idle high.
- `RX_DATA`  out  8  last correctly framed byte; holds until the next good frame.
- `RX_STATUS`  out  1  one-cycle pulse: `RX_DATA` just updated.
- `RX_ERR`  out  1  one-cycle pulse: framing error (stop bit sampled 0).
- `RX_BUSY`  out  1  high in every state except IDLE.

## Operation
- Synchronizer: `UART_RX` passes through `SYNC_STAGES` flops, reset value 1, giving `rx_s`; the falling-edge detect is `rx_s` = 0 with the previous `rx_s` = 1.
- Counters: tick counter `tcnt` is log2(`OVERSAMPLE`) bits and counts only on `BRclk` cycles. Bit counter `bcnt` is 3 bits.
- States:
  - IDLE: on a falling edge of `rx_s`, clear `tcnt` and go to START. Edge detection does not require `BRclk`.
  - START: on the `BRclk` where `tcnt` = `MID`-1, sample `rx_s`. 0 → clear `tcnt` and `bcnt`, go to DATA. 1 → glitch; return to IDLE with no output pulse.
  - DATA: on the `BRclk` where `tcnt` = `OVERSAMPLE`-1 (the bit centre), shift `rx_s` into bit[`bcnt`] of the shift register and increment `bcnt`. After bit 7, go to STOP. `tcnt` wraps to 0 naturally.
  - STOP: at the bit centre, sample `rx_s`. 1 → load `RX_DATA` from the shift register, pulse `RX_STATUS`, go to IDLE. 0 → pulse `RX_ERR`, leave `RX_DATA` unchanged, go to BREAK.
  - BREAK: wait for `rx_s` = 1, then go to IDLE. A line held low never yields repeated frames or errors.
- No receive buffer: an unread byte is overwritten by the next good frame; overrun is the register block's concern.
- A falling edge seen in IDLE directly after STOP starts the next frame, so back-to-back frames are supported.
- `reset` mid-frame: state goes to IDLE, the partial byte is discarded, no pulse is emitted.

## Timing
- Reset values: `RX_DATA` = 8'h00, `RX_STATUS` = 0, `RX_ERR` = 0, `RX_BUSY` = 0; state IDLE; counters 0; synchronizer flops 1.
- Input latency: `SYNC_STAGES` `sysclk` cycles from a pin change to `rx_s`.
- `RX_STATUS` / `RX_ERR`: registered; high for exactly the one cycle after the `sysclk` edge that samples the stop bit. `RX_DATA` changes on that same edge.
- Frame latency: the stop sample occurs `MID` + 9·`OVERSAMPLE` ticks after edge detection (152 ticks with defaults).
- `RX_STATUS` and `RX_ERR` are never high together.
- `RX_BUSY` rises the cycle after edge detection and falls with the return to IDLE.

## Structure
- Shared package `uart_pkg` holds the constants shared with the transmitter: `OVERSAMPLE` default, data width 8, and idle level 1. It also holds the receiver state encoding: IDLE, START, DATA, STOP, BREAK.
- One sub-module, `uart_rx_sync`: `SYNC_STAGES`-deep synchronizer plus falling-edge detector, outputs `rx_s` and `fall`.
- The FSM, counters and shift register live in `uart_receiver`.

## Test plan
- Good frame: `BRclk` every 4 cycles, send 8'hA5 8N1 at 16 ticks/bit → one `RX_STATUS` pulse 152 ticks (±1 tick + sync) after the start edge, `RX_DATA` = 8'hA5, `RX_ERR` stays 0.
- Back-to-back: send 8'h00, 8'hFF, 8'h3C with no idle gap → three `RX_STATUS` pulses, `RX_DATA` sequence 00, FF, 3C.
- Glitch: a 3-tick low pulse on idle line → returns to IDLE, no `RX_STATUS`/`RX_ERR`, `RX_DATA` unchanged.
- Framing error: send 8'h5A with stop bit 0 and the line held low 40 ticks → single `RX_ERR` pulse, `RX_DATA` keeps its previous value. No further pulses until the line goes high; a following 8'h81 frame is received correctly.
- Reset mid-frame: assert `reset` for 1 cycle after bit 3 of 8'hC3 → all outputs at reset values, no pulse. The next 8'h42 frame is received correctly.
- `BRclk` tied high: send 8'h96 at 16 `sysclk` per bit → `RX_DATA` = 8'h96 with one `RX_STATUS` pulse.
